irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_gateway.sv | 67 ++++++
 rtl/irq_arbiter.sv | 165 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: register indices,
// source-index width and the per-source gateway state encoding.
package irq_pkg;

  localparam int MAX_SRC = 15;
  localparam int IDX_W   = 4;

  localparam logic [3:0] REG_ENABLE  = 4'h0;
  localparam logic [3:0] REG_EDGE    = 4'h1;
  localparam logic [3:0] REG_PRIO    = 4'h2;
  localparam logic [3:0] REG_THRESH  = 4'h3;
  localparam logic [3:0] REG_PENDING = 4'h4;
  localparam logic [3:0] REG_CLAIM   = 4'h5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: turns a synchronized line into an
// IDLE/PENDING/CLAIMED request, remembering edges that arrive while claimed.
module irq_gateway
  import irq_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      edge_mode,
  input  logic      sync_in,
  input  logic      claim,
  input  logic      complete,
  output gw_state_e state
);

  gw_state_e state_d, state_q;
  logic      rearm_d, rearm_q;
  logic      prev_d, prev_q;
  logic      edge_trig;
  logic      trig;

  // An edge seen in the claim cycle or while claimed re-pends on complete.
  always_comb begin
    prev_d    = sync_in;
    edge_trig = edge_mode & sync_in & ~prev_q;
    trig      = edge_mode ? edge_trig : sync_in;
    state_d   = state_q;
    rearm_d   = rearm_q;
    case (state_q)
      IDLE: begin
        if (trig) state_d = PENDING;
      end
      PENDING: begin
        if (claim) begin
          state_d = CLAIMED;
          rearm_d = edge_trig;
        end
      end
      CLAIMED: begin
        if (complete) begin
          state_d = (rearm_q | edge_trig) ? PENDING : IDLE;
          rearm_d = 1'b0;
        end else if (edge_trig) begin
          rearm_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rearm_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rearm_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      prev_q  <= prev_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes NUM_SRC lines, gates them per source and
// picks the highest-priority enabled request above threshold via a claim/complete CSR.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [3:0]         addr,
  input  logic [31:0]        wdata,
  input  logic               write_en,
  input  logic               read_en,
  output logic [31:0]        rdata,
  output logic               irq_out
);

  localparam int PRIO_BITS = NUM_SRC * PRIO_W;
  localparam int PRIO_VIS  = (PRIO_BITS > 32) ? 32 : PRIO_BITS;
  localparam int LEAVES    = 16;
  localparam int NODES     = 2 * LEAVES - 1;

  logic [NUM_SRC-1:0]   sync1_d, sync1_q, sync2_d, sync2_q;
  logic [NUM_SRC-1:0]   enable_d, enable_q, edge_d, edge_q;
  logic [PRIO_BITS-1:0] prio_d, prio_q;
  logic [PRIO_W-1:0]    thresh_d, thresh_q;
  logic [31:0]          rdata_d, rdata_q, rd_mux;
  logic                 irq_d, irq_q;

  gw_state_e            gw_state [NUM_SRC];
  logic [NUM_SRC-1:0]   pending, cand, claim_vec, complete_vec;
  logic                 claim_rd, claim_wr;

  logic                 node_valid [NODES];
  logic [PRIO_W-1:0]    node_prio  [NODES];
  logic [IDX_W-1:0]     node_idx   [NODES];
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;

  always_comb begin
    sync1_d = irq_src;
    sync2_d = sync1_q;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk       (clk),
      .reset     (reset),
      .edge_mode (edge_q[g]),
      .sync_in   (sync2_q[g]),
      .claim     (claim_vec[g]),
      .complete  (complete_vec[g]),
      .state     (gw_state[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pending[i] = (gw_state[i] == PENDING);
      cand[i]    = pending[i] & enable_q[i]
                 & (prio_q[i*PRIO_W +: PRIO_W] != '0)
                 & (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
    end
  end

  // Heap-ordered comparison tree; the left child always holds the lower
  // indices, so it wins ties.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_valid[n] = 1'b0;
      node_prio[n]  = '0;
      node_idx[n]   = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      node_valid[LEAVES-1+i] = cand[i];
      node_prio[LEAVES-1+i]  = prio_q[i*PRIO_W +: PRIO_W];
      node_idx[LEAVES-1+i]   = IDX_W'(i);
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (node_valid[2*n+2] &&
          (!node_valid[2*n+1] || (node_prio[2*n+2] > node_prio[2*n+1]))) begin
        node_valid[n] = node_valid[2*n+2];
        node_prio[n]  = node_prio[2*n+2];
        node_idx[n]   = node_idx[2*n+2];
      end else begin
        node_valid[n] = node_valid[2*n+1];
        node_prio[n]  = node_prio[2*n+1];
        node_idx[n]   = node_idx[2*n+1];
      end
    end
    win_valid = node_valid[0];
    win_idx   = node_idx[0];
  end

  always_comb begin
    claim_rd = read_en & (addr == REG_CLAIM);
    claim_wr = write_en & (addr == REG_CLAIM);
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i]    = claim_rd & win_valid & (win_idx == IDX_W'(i));
      complete_vec[i] = claim_wr & (wdata == 32'(i + 1));
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    prio_d   = prio_q;
    thresh_d = thresh_q;
    if (write_en) begin
      case (addr)
        REG_ENABLE: enable_d = wdata[NUM_SRC-1:0];
        REG_EDGE:   edge_d   = wdata[NUM_SRC-1:0];
        REG_PRIO:   prio_d[PRIO_VIS-1:0] = wdata[PRIO_VIS-1:0];
        REG_THRESH: thresh_d = wdata[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_ENABLE:  rd_mux[NUM_SRC-1:0]  = enable_q;
      REG_EDGE:    rd_mux[NUM_SRC-1:0]  = edge_q;
      REG_PRIO:    rd_mux[PRIO_VIS-1:0] = prio_q[PRIO_VIS-1:0];
      REG_THRESH:  rd_mux[PRIO_W-1:0]   = thresh_q;
      REG_PENDING: rd_mux[NUM_SRC-1:0]  = pending;
      REG_CLAIM: begin
        if (win_valid) rd_mux[IDX_W:0] = {1'b0, win_idx} + (IDX_W+1)'(1);
      end
      default: ;
    endcase
    rdata_d = read_en ? rd_mux : rdata_q;
    irq_d   = |cand;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      prio_q   <= '0;
      thresh_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata   = rdata_q;
  assign irq_out = irq_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: a behavioural model predicts every read
// and the irq_out level; a negedge monitor compares them against the DUT.
module tb_irq_arbiter;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;
  localparam int S_IDLE  = 0;
  localparam int S_PEND  = 1;
  localparam int S_CLMD  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] irq_src;
  logic [3:0]         addr;
  logic [31:0]        wdata;
  logic               write_en;
  logic               read_en;
  logic [31:0]        rdata;
  logic               irq_out;

  irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .addr     (addr),
    .wdata    (wdata),
    .write_en (write_en),
    .read_en  (read_en),
    .rdata    (rdata),
    .irq_out  (irq_out)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;

  int          m_state [NUM_SRC];
  bit          m_rearm [NUM_SRC];
  bit          m_s1    [NUM_SRC];
  bit          m_s2    [NUM_SRC];
  bit          m_prev  [NUM_SRC];
  int          m_en, m_edge, m_prio, m_thresh;
  bit          m_irq;
  logic [31:0] exp_q [$];
  int          last_claim;
  logic        rd_issued = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prio_of(input int i);
    return (m_prio >> (i * PRIO_W)) & ((1 << PRIO_W) - 1);
  endfunction

  // Highest priority among enabled pending sources above threshold, lowest index on ties.
  function automatic int pick_winner();
    int best = -1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_state[i] == S_PEND && m_en[i] && prio_of(i) > 0 && prio_of(i) > m_thresh) begin
        if (best < 0 || prio_of(i) > prio_of(best)) best = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      m_state[i] = S_IDLE;
      m_rearm[i] = 0;
      m_s1[i]    = 0;
      m_s2[i]    = 0;
      m_prev[i]  = 0;
    end
    m_en = 0; m_edge = 0; m_prio = 0; m_thresh = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int          w;
    int          cidx;
    logic [31:0] rd;
    bit          claim_now;
    if (reset) begin
      model_reset();
      return;
    end
    w = pick_winner();
    claim_now = read_en && addr == 4'd5 && w >= 0;
    if (read_en) begin
      rd = 0;
      case (addr)
        4'd0: rd = 32'(m_en);
        4'd1: rd = 32'(m_edge);
        4'd2: rd = 32'(m_prio);
        4'd3: rd = 32'(m_thresh);
        4'd4: for (int i = 0; i < NUM_SRC; i++) rd[i] = (m_state[i] == S_PEND);
        4'd5: rd = 32'(w + 1);
        default: rd = 0;
      endcase
      exp_q.push_back(rd);
      if (addr == 4'd5) last_claim = w + 1;
    end
    m_irq = (w >= 0);
    cidx = (write_en && addr == 4'd5 && wdata >= 1 && wdata <= NUM_SRC) ? int'(wdata) - 1 : -1;
    for (int i = 0; i < NUM_SRC; i++) begin
      bit etrig;
      bit trig;
      etrig = m_edge[i] && m_s2[i] && !m_prev[i];
      trig  = m_edge[i] ? etrig : m_s2[i];
      if (claim_now && i == w) begin
        m_state[i] = S_CLMD;
        m_rearm[i] = etrig;
      end else if (m_state[i] == S_IDLE) begin
        if (trig) m_state[i] = S_PEND;
      end else if (m_state[i] == S_CLMD) begin
        if (i == cidx) begin
          m_state[i] = (m_rearm[i] || etrig) ? S_PEND : S_IDLE;
          m_rearm[i] = 0;
        end else if (etrig) begin
          m_rearm[i] = 1;
        end
      end
      m_prev[i] = m_s2[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = irq_src[i];
    end
    if (write_en) begin
      case (addr)
        4'd0: m_en     = int'(wdata & 32'hFF);
        4'd1: m_edge   = int'(wdata & 32'hFF);
        4'd2: m_prio   = int'(wdata & 32'hFF_FFFF);
        4'd3: m_thresh = int'(wdata & 32'h7);
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a);
    addr = a; read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  task automatic pulse(input int s);
    irq_src[s] = 1'b1;
    idle(3);
    irq_src[s] = 1'b0;
    idle(3);
  endtask

  always @(posedge clk) rd_issued <= read_en & ~reset;

  // Monitor: irq_out every cycle, rdata whenever a read was issued the cycle before.
  always @(negedge clk) begin
    if (reset) begin
      check_output("reset_irq_out", 32'(irq_out), 32'd0);
      check_output("reset_rdata", rdata, 32'd0);
    end else begin
      check_output("irq_out", 32'(irq_out), 32'(m_irq));
      if (rd_issued) begin
        if (exp_q.size() == 0) begin
          check_output("rdata_unexpected", rdata, 32'hDEAD_BEEF);
        end else begin
          check_output("rdata", rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic apply_stimulus();
    int op;
    // Reset and register readback
    irq_src = '0; addr = '0; wdata = '0; write_en = 0; read_en = 0; reset = 0;
    #2 reset = 1;
    idle(3);
    reset = 0;
    idle(1);
    for (int a = 0; a < 8; a++) read_reg(4'(a));

    // Single edge source: request, claim, drop
    write_reg(4'd1, 32'h1); write_reg(4'd2, 32'd3); write_reg(4'd3, 32'd0); write_reg(4'd0, 32'h1);
    irq_src[0] = 1'b1;
    idle(5);
    read_reg(4'd5);
    idle(3);
    write_reg(4'd5, 32'(last_claim));
    irq_src[0] = 1'b0;
    idle(3);

    // Priority order and tie-break among level sources 1, 2, 5
    write_reg(4'd1, 32'h0);
    write_reg(4'd2, (32'd7 << 3) | (32'd5 << 6) | (32'd5 << 15));
    write_reg(4'd0, 32'h26);
    irq_src = 8'h26;
    idle(4);
    irq_src = '0;
    idle(2);
    repeat (3) begin
      read_reg(4'd5);
      idle(1);
      write_reg(4'd5, 32'(last_claim));
      idle(1);
    end
    read_reg(4'd5);

    // Threshold masking
    write_reg(4'd3, 32'd4); write_reg(4'd2, 32'd4 << 9); write_reg(4'd0, 32'h8);
    irq_src[3] = 1'b1; idle(4); irq_src[3] = 1'b0; idle(4);
    write_reg(4'd3, 32'd3);
    idle(3);
    read_reg(4'd5);
    write_reg(4'd5, 32'(last_claim));
    write_reg(4'd3, 32'd0);

    // Edge re-arm while claimed
    write_reg(4'd1, 32'h1); write_reg(4'd2, 32'd3); write_reg(4'd0, 32'h1);
    pulse(0);
    read_reg(4'd5);
    pulse(0);
    write_reg(4'd5, 32'd1);
    idle(1);
    read_reg(4'd4);
    read_reg(4'd5);
    write_reg(4'd5, 32'(last_claim));
    idle(2);

    // Level re-entry after complete, then line dropped before complete
    write_reg(4'd1, 32'h0); write_reg(4'd2, 32'd2 << 12); write_reg(4'd0, 32'h10);
    irq_src[4] = 1'b1;
    idle(4);
    read_reg(4'd5);
    write_reg(4'd5, 32'(last_claim));
    read_reg(4'd4);
    read_reg(4'd4);
    read_reg(4'd5);
    irq_src[4] = 1'b0;
    idle(3);
    write_reg(4'd5, 32'(last_claim));
    idle(1);
    read_reg(4'd4);
    read_reg(4'd4);

    // Same-cycle read and write
    addr = 4'd0; wdata = 32'hFF; read_en = 1; write_en = 1;
    tick();
    read_en = 0; write_en = 0;
    read_reg(4'd0);

    // Reset while a source is claimed
    write_reg(4'd1, 32'h1); write_reg(4'd2, 32'd3); write_reg(4'd0, 32'h1);
    pulse(0);
    read_reg(4'd5);
    idle(1);
    reset = 1;
    idle(2);
    reset = 0;
    idle(1);
    for (int a = 0; a < 6; a++) read_reg(4'(a));
    write_reg(4'd5, 32'd1);
    read_reg(4'd4);
    read_reg(4'd5);

    // Randomized traffic
    write_reg(4'd1, 32'h0F);
    write_reg(4'd2, 32'h00FA_C688);
    write_reg(4'd0, 32'hFF);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) irq_src = NUM_SRC'($urandom);
      op = int'($urandom_range(0, 9));
      addr = (op < 5) ? 4'd5 : 4'($urandom_range(0, 7));
      read_en  = (op < 4) || (op == 7);
      write_en = (op >= 3 && op < 6) || (op == 8);
      if (addr == 4'd5)      wdata = 32'($urandom_range(0, 9));
      else if (addr == 4'd3) wdata = 32'($urandom_range(0, 3));
      else if (addr == 4'd0) wdata = 32'($urandom) | 32'h11;
      else                   wdata = $urandom;
      tick();
      read_en = 0; write_en = 0;
    end
    idle(3);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule
